// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system-controller response scheduler:
// dequeue FSM encoding, byte-split order and a constant clog2 helper.
package sys_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESENT   = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  // ALU results leave low byte first
  localparam bit LSB_FIRST = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_sched_if.sv
// Response sources in, UART TX handshake out; slave is the scheduler side.
interface sys_ctrl_tx_sched_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   RdDATA;
  logic                    RdDATA_VLD;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    OUT_Valid;
  logic                    Busy;
  logic                    enable_pulse;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;

  modport master (
    output RdDATA, RdDATA_VLD, ALU_OUT, OUT_Valid, Busy, enable_pulse,
    input  TX_P_DATA, TX_D_VLD
  );

  modport slave (
    input  RdDATA, RdDATA_VLD, ALU_OUT, OUT_Valid, Busy, enable_pulse,
    output TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/sys_ctrl_rsp_fifo.sv
// Byte FIFO taking up to three writes and one pop per cycle; enabled write
// slots are packed in slot order starting at the write pointer.
module sys_ctrl_rsp_fifo
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int PW        = clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [2:0]                 wr_en_i,
  input  logic [2:0][DATA_WIDTH-1:0] wr_data_i,
  input  logic                       pop_i,
  output logic [CW-1:0]              count_o,
  output logic [DATA_WIDTH-1:0]      head_o
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx_s;
  logic [CW-1:0] count_q, count_d, n_wr_s;

  // Pack enabled writes, advance pointers, update occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_idx_s = wr_ptr_q;
    n_wr_s   = {CW{1'b0}};
    for (int k = 0; k < 3; k++) begin
      if (wr_en_i[k]) begin
        mem_d[wr_idx_s] = wr_data_i[k];
        wr_idx_s        = wr_idx_s + PW'(1);
        n_wr_s          = n_wr_s + CW'(1);
      end else begin
        n_wr_s = n_wr_s;
      end
    end
    wr_ptr_d = wr_idx_s;
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_q + n_wr_s - CW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + n_wr_s;
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sys_ctrl_tx_sched.sv
// Response scheduler: whole-response accept/drop into a byte FIFO, then a
// one-byte-in-flight handshake toward the UART TX with a Busy-rise timeout.
module sys_ctrl_tx_sched
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 2 * DATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int BUSY_TO    = 8
) (
  input  logic               CLK,
  input  logic               RST,
  sys_ctrl_tx_sched_if.slave bus,
  output logic               FIFO_FULL,
  output logic               RSP_OVF
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam int TW = clog2(BUSY_TO + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] BUSY_TO_C = TW'(BUSY_TO);

  tx_state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]      tx_data_q, tx_data_d;
  logic                       tx_vld_q, tx_vld_d;
  logic [TW-1:0]              to_cnt_q, to_cnt_d;
  logic                       ovf_q, ovf_d;

  logic [CW-1:0]              count_s, free_s, free_after_s;
  logic [DATA_WIDTH-1:0]      head_s, alu_lsb_s, alu_msb_s;
  logic [2:0]                 wr_en_s;
  logic [2:0][DATA_WIDTH-1:0] wr_data_s;
  logic                       rd_acc_s, alu_acc_s, drop_s, pop_s;

  assign alu_lsb_s = bus.ALU_OUT[DATA_WIDTH-1:0];
  assign alu_msb_s = bus.ALU_OUT[ALU_WIDTH-1:DATA_WIDTH];

  // Room is judged on the pre-pop count, so a same-cycle pop never helps
  always_comb begin
    free_s       = DEPTH_C - count_s;
    rd_acc_s     = bus.RdDATA_VLD && (free_s >= CW'(1));
    free_after_s = free_s - {{(CW-1){1'b0}}, rd_acc_s};
    alu_acc_s    = bus.OUT_Valid && (free_after_s >= CW'(2));
    drop_s       = (bus.RdDATA_VLD && !rd_acc_s) || (bus.OUT_Valid && !alu_acc_s);
    ovf_d        = ovf_q | drop_s;
    wr_en_s      = {alu_acc_s, alu_acc_s, rd_acc_s};
    wr_data_s[0] = bus.RdDATA;
    wr_data_s[1] = LSB_FIRST ? alu_lsb_s : alu_msb_s;
    wr_data_s[2] = LSB_FIRST ? alu_msb_s : alu_lsb_s;
  end

  sys_ctrl_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .wr_en_i   (wr_en_s),
    .wr_data_i (wr_data_s),
    .pop_i     (pop_s),
    .count_o   (count_s),
    .head_o    (head_s)
  );

  // Dequeue FSM next-state and output logic
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;
    to_cnt_d  = to_cnt_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((count_s != {CW{1'b0}}) && !bus.Busy) begin
          tx_data_d = head_s;
          tx_vld_d  = 1'b1;
          state_d   = ST_PRESENT;
        end else begin
          tx_vld_d = 1'b0;
        end
      end
      ST_PRESENT: begin
        if (bus.enable_pulse) begin
          tx_vld_d = 1'b0;
          pop_s    = 1'b1;
          to_cnt_d = {TW{1'b0}};
          state_d  = ST_WAIT_BUSY;
        end else begin
          tx_vld_d = 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        if (bus.Busy) begin
          state_d = ST_WAIT_DONE;
        end else if (bus.enable_pulse) begin
          // No Busy after BUSY_TO strobes: byte counts as sent, not retried
          if ((to_cnt_q + TW'(1)) == BUSY_TO_C) begin
            to_cnt_d = {TW{1'b0}};
            state_d  = ST_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end else begin
          to_cnt_d = to_cnt_q;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.Busy) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tx_vld_d = 1'b0;
      end
    endcase
  end

  // FSM, TX output and sticky overflow registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      tx_data_q <= {DATA_WIDTH{1'b0}};
      tx_vld_q  <= 1'b0;
      to_cnt_q  <= {TW{1'b0}};
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      to_cnt_q  <= to_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.TX_P_DATA = tx_data_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign FIFO_FULL     = (count_s == DEPTH_C);
  assign RSP_OVF       = ovf_q;

endmodule
